// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, sequencer state encoding and widths.
package cpu4_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } seq_state_t;

  // Control-flow opcodes never reach the datapath, even when CALL/RET are compiled out.
  function automatic logic is_datapath_op(input logic [3:0] op);
    return !(op inside {OP_HLT, OP_JMP, OP_JZ, OP_CALL, OP_RET});
  endfunction

endpackage

// File: rtl/return_stack.sv
// Two-deep LIFO of return addresses; a push when full drops the oldest entry.
module return_stack
  import cpu4_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  logic [PC_W-1:0] entry [2];
  logic [1:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (push) begin
      count <= (count == 2'd2) ? 2'd2 : count + 2'd1;
    end else if (pop && count != 2'd0) begin
      count <= count - 2'd1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      entry[1] <= entry[0];
      entry[0] <= din;
    end else if (pop) begin
      entry[0] <= entry[1];
    end
  end

  assign dout  = entry[0];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and FETCH/DECODE/EXEC sequencer for the 4-bit CPU.
// Optional CALL/RET return stack enabled by defining PC_SEQ_CALL_STACK_EN.
module pc_sequencer
  import cpu4_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  output logic [PC_W-1:0]    rom_addr,
  output logic [3:0]         ir_opcode,
  output logic [3:0]         ir_operand,
  output logic               exec_strobe,
  output logic               busy,
  output logic               halted,
  output logic               stack_err
);

  seq_state_t         state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               single_step;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_next;

  assign pc_inc     = pc + 4'd1;
  assign rom_addr   = pc;
  assign ir_opcode  = ir[7:4];
  assign ir_operand = ir[3:0];

`ifdef PC_SEQ_CALL_STACK_EN
  logic            stk_push;
  logic            stk_pop;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_dout;
  logic            err_set;

  return_stack u_return_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_next  = pc_inc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    case (ir_opcode)
      OP_HLT:  pc_next = pc;
      OP_JMP:  pc_next = ir_operand;
      OP_JZ:   pc_next = zero_flag ? ir_operand : pc_inc;
      OP_CALL: begin
        pc_next  = ir_operand;
        stk_push = (state == ST_EXEC);
        err_set  = stk_full;
      end
      OP_RET: begin
        pc_next = stk_empty ? pc_inc : stk_dout;
        stk_pop = (state == ST_EXEC) && !stk_empty;
        err_set = stk_empty;
      end
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (state == ST_EXEC && err_set) begin
      stack_err <= 1'b1;
    end
  end
`else
  // CALL and RET fall into the default arm and behave as NOPs.
  always_comb begin
    pc_next = pc_inc;
    case (ir_opcode)
      OP_HLT:  pc_next = pc;
      OP_JMP:  pc_next = ir_operand;
      OP_JZ:   pc_next = zero_flag ? ir_operand : pc_inc;
      default: pc_next = pc_inc;
    endcase
  end

  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      single_step <= 1'b0;
      exec_strobe <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run || step) begin
            state       <= ST_FETCH;
            single_step <= !run;
            busy        <= 1'b1;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          ir          <= instr_in;
          exec_strobe <= is_datapath_op(instr_in[7:4]);
          state       <= ST_EXEC;
        end
        ST_EXEC: begin
          exec_strobe <= 1'b0;
          pc          <= pc_next;
          if (ir_opcode == OP_HLT) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (run && !single_step) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with a registered ROM model.
// Covers the CALL/RET stack when PC_SEQ_CALL_STACK_EN is defined, NOP behaviour otherwise.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       zero_flag;
  logic [7:0] instr_in;
  logic [3:0] rom_addr;
  logic [3:0] ir_opcode;
  logic [3:0] ir_operand;
  logic       exec_strobe;
  logic       busy;
  logic       halted;
  logic       stack_err;

  logic [7:0] rom [16];
  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(.RESET_PC(4'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .instr_in    (instr_in),
    .zero_flag   (zero_flag),
    .rom_addr    (rom_addr),
    .ir_opcode   (ir_opcode),
    .ir_operand  (ir_operand),
    .exec_strobe (exec_strobe),
    .busy        (busy),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_in <= rom[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; zero_flag = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    fill_rom(8'h10);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; zero_flag = 1'b0;
    tick; tick;
    vectors++; if (rom_addr !== 4'h0) begin $display("FAIL reset_rom_addr: got %h want 0", rom_addr); miscompares++; end
    vectors++; if ({ir_opcode, ir_operand} !== 8'h00) begin $display("FAIL reset_ir: got %h want 00", {ir_opcode, ir_operand}); miscompares++; end
    vectors++; if ({exec_strobe, busy, halted, stack_err} !== 4'b0000) begin $display("FAIL reset_ctl: got %b want 0000", {exec_strobe, busy, halted, stack_err}); miscompares++; end
    rst_n = 1'b1;
    tick;
    vectors++; if (busy !== 1'b0) begin $display("FAIL idle_no_run: busy got %b want 0", busy); miscompares++; end
  endtask

  task automatic test_sequential;
    fill_rom(8'h10);
    apply_reset;
    run = 1'b1;
    for (int j = 0; j < 17; j++) begin
      tick;
      vectors++; if (rom_addr !== 4'(j)) begin $display("FAIL seq_addr[%0d]: got %h want %h", j, rom_addr, 4'(j)); miscompares++; end
      vectors++; if ({busy, exec_strobe} !== 2'b10) begin $display("FAIL seq_fetch_ctl[%0d]: busy,strobe got %b want 10", j, {busy, exec_strobe}); miscompares++; end
      tick;
      vectors++; if (exec_strobe !== 1'b0) begin $display("FAIL seq_decode_strobe[%0d]: got %b want 0", j, exec_strobe); miscompares++; end
      tick;
      vectors++; if (exec_strobe !== 1'b1) begin $display("FAIL seq_exec_strobe[%0d]: got %b want 1", j, exec_strobe); miscompares++; end
      if (j == 16) run = 1'b0;
    end
    tick;
    vectors++; if ({busy, exec_strobe} !== 2'b00) begin $display("FAIL seq_stop_ctl: busy,strobe got %b want 00", {busy, exec_strobe}); miscompares++; end
    vectors++; if (rom_addr !== 4'h1) begin $display("FAIL seq_stop_addr: got %h want 1", rom_addr); miscompares++; end
    vectors++; if (ir_opcode !== 4'h1) begin $display("FAIL seq_ir_opcode: got %h want 1", ir_opcode); miscompares++; end
  endtask

  task automatic test_jmp_hlt;
    fill_rom(8'h10);
    rom[0] = 8'hE5;
    rom[5] = 8'hF0;
    apply_reset;
    run = 1'b1;
    tick;
    vectors++; if (rom_addr !== 4'h0) begin $display("FAIL jmp_fetch_addr: got %h want 0", rom_addr); miscompares++; end
    tick; tick;
    vectors++; if (exec_strobe !== 1'b0) begin $display("FAIL jmp_strobe: got %b want 0", exec_strobe); miscompares++; end
    vectors++; if ({ir_opcode, ir_operand} !== 8'hE5) begin $display("FAIL jmp_ir: got %h want E5", {ir_opcode, ir_operand}); miscompares++; end
    tick;
    vectors++; if (rom_addr !== 4'h5) begin $display("FAIL jmp_target: got %h want 5", rom_addr); miscompares++; end
    tick; tick;
    vectors++; if ({halted, busy, exec_strobe} !== 3'b010) begin $display("FAIL hlt_exec_ctl: halted,busy,strobe got %b want 010", {halted, busy, exec_strobe}); miscompares++; end
    tick;
    vectors++; if ({halted, busy} !== 2'b10) begin $display("FAIL hlt_cycle7: halted,busy got %b want 10", {halted, busy}); miscompares++; end
    run = 1'b0; step = 1'b1;
    tick;
    step = 1'b0; run = 1'b1;
    tick; tick; tick;
    vectors++; if (rom_addr !== 4'h5) begin $display("FAIL hlt_hold_addr: got %h want 5", rom_addr); miscompares++; end
    vectors++; if ({halted, busy} !== 2'b10) begin $display("FAIL hlt_hold_ctl: halted,busy got %b want 10", {halted, busy}); miscompares++; end
    run = 1'b0;
  endtask

  task automatic jz_case(input logic z, input logic [3:0] exp_addr);
    fill_rom(8'h10);
    rom[2] = 8'hD9;
    apply_reset;
    zero_flag = z;
    run = 1'b1;
    repeat (6) tick;
    tick;
    vectors++; if (rom_addr !== 4'h2) begin $display("FAIL jz%0d_fetch_addr: got %h want 2", z, rom_addr); miscompares++; end
    tick; tick;
    vectors++; if (exec_strobe !== 1'b0) begin $display("FAIL jz%0d_strobe: got %b want 0", z, exec_strobe); miscompares++; end
    tick;
    vectors++; if (rom_addr !== exp_addr) begin $display("FAIL jz%0d_next_addr: got %h want %h", z, rom_addr, exp_addr); miscompares++; end
    run = 1'b0;
  endtask

  task automatic test_jz;
    jz_case(1'b1, 4'h9);
    jz_case(1'b0, 4'h3);
  endtask

  task automatic test_step;
    fill_rom(8'h10);
    apply_reset;
    tick;
    vectors++; if (busy !== 1'b0) begin $display("FAIL step_pre_idle: busy got %b want 0", busy); miscompares++; end
    step = 1'b1;
    tick;
    step = 1'b0;
    vectors++; if ({busy, rom_addr} !== 5'b1_0000) begin $display("FAIL step_n1: busy,addr got %b want 10000", {busy, rom_addr}); miscompares++; end
    tick;
    vectors++; if ({busy, exec_strobe} !== 2'b10) begin $display("FAIL step_n2: busy,strobe got %b want 10", {busy, exec_strobe}); miscompares++; end
    step = 1'b1;
    tick;
    step = 1'b0;
    vectors++; if ({busy, exec_strobe} !== 2'b11) begin $display("FAIL step_n3: busy,strobe got %b want 11", {busy, exec_strobe}); miscompares++; end
    tick;
    vectors++; if ({busy, exec_strobe} !== 2'b00) begin $display("FAIL step_n4: busy,strobe got %b want 00", {busy, exec_strobe}); miscompares++; end
    vectors++; if (rom_addr !== 4'h1) begin $display("FAIL step_pc: got %h want 1", rom_addr); miscompares++; end
    tick; tick;
    vectors++; if ({busy, rom_addr} !== 5'b0_0001) begin $display("FAIL step_ignored: busy,addr got %b want 00001", {busy, rom_addr}); miscompares++; end
    run = 1'b1; step = 1'b1;
    tick;
    step = 1'b0;
    tick; tick; tick;
    vectors++; if ({busy, rom_addr} !== 5'b1_0010) begin $display("FAIL run_wins: busy,addr got %b want 10010", {busy, rom_addr}); miscompares++; end
    run = 1'b0;
    tick; tick; tick;
    vectors++; if ({busy, rom_addr} !== 5'b0_0011) begin $display("FAIL run_drop: busy,addr got %b want 00011", {busy, rom_addr}); miscompares++; end
  endtask

  task automatic test_reset_mid;
    fill_rom(8'h10);
    apply_reset;
    run = 1'b1;
    repeat (5) tick;
    vectors++; if ({busy, rom_addr, ir_opcode} !== 9'b1_0001_0001) begin $display("FAIL mid_pre: busy,addr,op got %b want 100010001", {busy, rom_addr, ir_opcode}); miscompares++; end
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    vectors++; if ({rom_addr, ir_opcode, ir_operand} !== 12'h000) begin $display("FAIL mid_async_regs: got %h want 000", {rom_addr, ir_opcode, ir_operand}); miscompares++; end
    vectors++; if ({busy, exec_strobe, halted, stack_err} !== 4'b0000) begin $display("FAIL mid_async_ctl: got %b want 0000", {busy, exec_strobe, halted, stack_err}); miscompares++; end
    tick;
    vectors++; if ({busy, exec_strobe, rom_addr} !== 6'b00_0000) begin $display("FAIL mid_hold: got %b want 000000", {busy, exec_strobe, rom_addr}); miscompares++; end
    rst_n = 1'b1;
    tick;
    vectors++; if ({busy, exec_strobe} !== 2'b00) begin $display("FAIL mid_release: busy,strobe got %b want 00", {busy, exec_strobe}); miscompares++; end
  endtask

`ifdef PC_SEQ_CALL_STACK_EN
  task automatic test_call_ret;
    logic [3:0] path [7];
    path = '{4'h0, 4'h4, 4'h8, 4'hA, 4'h9, 4'h5, 4'h6};
    fill_rom(8'h10);
    rom[0] = 8'hC4; rom[4] = 8'hC8; rom[8] = 8'hCA; rom[10] = 8'hB0;
    rom[9] = 8'hB0; rom[5] = 8'hB0; rom[6] = 8'hF0;
    apply_reset;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      vectors++; if (rom_addr !== path[i]) begin $display("FAIL call_path[%0d]: got %h want %h", i, rom_addr, path[i]); miscompares++; end
      tick; tick;
      vectors++; if (exec_strobe !== 1'b0) begin $display("FAIL call_strobe[%0d]: got %b want 0", i, exec_strobe); miscompares++; end
      if (i == 2) begin
        vectors++; if (stack_err !== 1'b0) begin $display("FAIL call_err_early: got %b want 0", stack_err); miscompares++; end
      end
    end
    tick;
    vectors++; if ({halted, stack_err, rom_addr} !== 6'b11_0110) begin $display("FAIL call_end: halted,err,addr got %b want 110110", {halted, stack_err, rom_addr}); miscompares++; end
    run = 1'b0;
  endtask
`else
  task automatic test_call_ret;
    logic [3:0] path [3];
    path = '{4'h0, 4'h1, 4'h2};
    fill_rom(8'h10);
    rom[0] = 8'hC4; rom[1] = 8'hB0; rom[2] = 8'hF0;
    apply_reset;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (rom_addr !== path[i]) begin $display("FAIL nop_path[%0d]: got %h want %h", i, rom_addr, path[i]); miscompares++; end
      tick; tick;
      vectors++; if (exec_strobe !== 1'b0) begin $display("FAIL nop_strobe[%0d]: got %b want 0", i, exec_strobe); miscompares++; end
    end
    tick;
    vectors++; if ({halted, stack_err, rom_addr} !== 6'b10_0010) begin $display("FAIL nop_end: halted,err,addr got %b want 100010", {halted, stack_err, rom_addr}); miscompares++; end
    run = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_sequential;
    test_jmp_hlt;
    test_jz;
    test_step;
    test_reset_mid;
    test_call_ret;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the 4-bit microprocessor. It owns the 4-bit program counter and the fetch/decode/execute state machine, and it addresses the instruction ROM. It resolves control-flow opcodes (JMP, JZ, HLT and, optionally, CALL/RET) internally. All other opcodes go to the ALU/register datapath as a single-cycle execute strobe with the decoded opcode and operand.

## Interface
Parameters:
- `RESET_PC`, `4'h0`: program-counter value after reset.

Ports:
- `clk`, in, 1: single system clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level; while high, execute instructions back to back.
- `step`, in, 1: single-cycle pulse; execute exactly one instruction from IDLE.
- `instr_in`, in, 8: ROM data, one-cycle registered latency after `rom_addr`. Bits [7:4] are the opcode; bits [3:0] are the operand.
- `zero_flag`, in, 1: ALU zero flag, sampled in EXEC.
- `rom_addr`, out, 4: current PC, driven to the ROM.
- `ir_opcode`, out, 4: latched opcode.
- `ir_operand`, out, 4: latched operand.
- `exec_strobe`, out, 1: one-cycle pulse in EXEC for datapath opcodes only.
- `busy`, out, 1: high in FETCH, DECODE and EXEC.
- `halted`, out, 1: high in HALT.
- `stack_err`, out, 1: sticky return-stack error; tied to 0 when the stack is compiled out.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset (async, `rst_n`=0):
  - state = IDLE, PC = `RESET_PC`, IR = 8'h00.
  - `exec_strobe`=0, `busy`=0, `halted`=0, `stack_err`=0.
  - Return stack empty.
- Reset mid-instruction aborts the instruction with no PC update and no strobe.
- IDLE → FETCH when `run`=1 or `step`=1. `step` is latched as single-step mode for that instruction.
- FETCH: `rom_addr`=PC. Next state is DECODE.
- DECODE: IR ← `instr_in`. Next state is EXEC.
- EXEC resolves the opcode:
  - 4'hF HLT: PC unchanged; next state HALT.
  - 4'hE JMP: PC ← operand.
  - 4'hD JZ: PC ← operand if `zero_flag`=1, else PC+1.
  - 4'hC CALL / 4'hB RET: see Configuration.
  - All other opcodes: `exec_strobe`=1 for one cycle; PC ← PC+1.
- After EXEC (unless HLT): next state is FETCH if `run`=1 and not single-step, else IDLE.
- `run` dropping during FETCH or DECODE: the current instruction completes, then the block returns to IDLE.
- `run` and `step` both high in IDLE: `run` wins and execution is continuous.
- `step` pulses outside IDLE are ignored.
- HALT is left only by reset; `run` and `step` are ignored there.
- PC arithmetic is modulo 16: 4'hF+1 wraps to 4'h0. There is no error on wrap.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). Throughput is 1 instruction per 3 cycles under `run`.
- `rom_addr` changes only on the EXEC→next edge; it is stable for the whole of FETCH and DECODE.
- `ir_opcode`/`ir_operand` are valid from the cycle after DECODE and are held until the next DECODE.
- `exec_strobe` is high only during the EXEC cycle, and is registered at the DECODE→EXEC edge.
- Step latency: `step` pulse in IDLE at cycle N → EXEC at N+3 → IDLE at N+4.
- `halted` rises in the cycle after the HLT EXEC.

## Configuration
- `PC_SEQ_CALL_STACK_EN` defined:
  - 2-entry return stack.
  - CALL pushes PC+1 (mod 16) and sets PC ← operand.
  - RET pops into PC.
  - CALL on a full stack discards the oldest entry and sets `stack_err`.
  - RET on an empty stack sets PC ← PC+1 and sets `stack_err`.
  - `stack_err` clears only on reset.
- Macro undefined:
  - CALL and RET are executed as NOPs: PC+1, no strobe.
  - `stack_err` is constant 0 and no stack storage is built.

## Structure
- Shared package `cpu4_pkg` holds:
  - Opcode constants: `OP_HLT`=4'hF, `OP_JMP`=4'hE, `OP_JZ`=4'hD, `OP_CALL`=4'hC, `OP_RET`=4'hB.
  - The state enum `seq_state_t`.
  - `PC_W`=4 and `INSTR_W`=8.
- One sub-module: `return_stack`. It is a 2-deep LIFO with push, pop, full, empty and dout, and is instantiated only under `PC_SEQ_CALL_STACK_EN`.

## Test plan
- Reset release, ROM all 8'h10, `run`=1: `rom_addr` sequence 0,1,2,…,F,0 at a 3-cycle cadence; `exec_strobe` pulses every 3rd cycle.
- ROM[0]=8'hE5 (JMP 5), ROM[5]=8'hF0: `rom_addr` 0→5, then `halted`=1 from cycle 7; later `run`/`step` pulses leave `rom_addr`=5.
- ROM[2]=8'hD9 (JZ 9): with `zero_flag`=1 the next `rom_addr` is 9; with `zero_flag`=0 it is 3; `exec_strobe` stays 0 in both cases.
- `run`=0, one `step` pulse at cycle N: `busy` for N+1..N+3, `exec_strobe` at N+3, IDLE at N+4, PC advanced by exactly 1.
- `rst_n` asserted during DECODE: all outputs return to reset values immediately, with no `exec_strobe`.
- With `PC_SEQ_CALL_STACK_EN` defined, ROM[0]=C4, ROM[4]=C8, ROM[8]=CA, ROM[A]=B0, ROM[9]=B0, ROM[5]=B0, ROM[6]=F0:
  - PC path 0,4,8,A,9,5,6.
  - The third CALL sets `stack_err`, so RET at 5 is a pop from empty: PC 5→6, then HLT.
